detect_timer_ctrl: RTL and testbench
====================================

// Module: detect_timer_ctrl
// PURPOSE
//   Sequencer between the serial pattern detector and its external timer/counter.
//   Arms the detector and loads/enables the timer when a detection pulse arrives.
//   Waits for timer terminal count, then holds off and re-arms or idles.
//   Sits above the detector/counter pair; driven by the system control block (start/stop).
// PARAMETERS
//   DCNT_W    8    width of saturating detection counter det_count
//   TIMEOUT   64   max cycles in ARMED without a detection; 0 disables the watchdog
//   HOLD_CYC  4    cycles spent in HOLD after timer expiry; must be >= 1
// PORTS
//   clk        in   1       clock
//   rst        in   1       reset; asynchronous, active-high
//   start      in   1       arm request, sampled in IDLE only
//   stop       in   1       abort; forces IDLE from any state
//   rearm      in   1       sampled at end of HOLD: 1 -> ARMED, 0 -> IDLE
//   det        in   1       1-cycle detection pulse from the sequence detector
//   tmr_co     in   1       timer terminal-count / carry-out
//   det_arm    out  1       enables the detector (state == ARMED)
//   tmr_init   out  1       timer load strobe (state == LOAD), exactly 1 cycle
//   tmr_en     out  1       timer count enable (state == RUN)
//   busy       out  1       state != IDLE
//   done       out  1       1-cycle pulse, first cycle of HOLD
//   timeout    out  1       1-cycle pulse, first cycle of IDLE after watchdog expiry
//   det_count  out  DCNT_W  detections accepted since reset, saturating at all-ones
//   state      out  3       current state encoding (debug)
// BEHAVIOUR
//   Reset: state=IDLE; every output 0; det_count=0; watchdog and hold counters 0.
//   States (3'd): IDLE=0, ARMED=1, LOAD=2, RUN=3, HOLD=4; others -> IDLE next cycle.
//   Priority: stop > tmr_co > det > watchdog. stop in IDLE with start keeps IDLE.
//   IDLE : start -> ARMED; watchdog cleared on entry to ARMED.
//   ARMED: det -> LOAD. Otherwise wdog++; TIMEOUT>0 and wdog==TIMEOUT-1 -> IDLE, timeout=1.
//   LOAD : det_count += 1 (saturating); -> RUN unconditionally.
//   RUN  : tmr_co -> HOLD, done=1 next cycle; det handled per CONFIGURATION.
//   HOLD : hold counter loaded HOLD_CYC-1 on entry, decrements; at 0 -> rearm ? ARMED : IDLE.
//   Latency: det high at edge n (ARMED) -> tmr_init high cycle n+1 -> tmr_en high from n+2.
//   det_arm/tmr_init/tmr_en/busy are decoded from the state register only (no input paths).
//   det/tmr_co outside their accepting state are ignored; det_count does not change.
//   stop or rst mid-RUN: tmr_en drops the next cycle (rst: immediately); no done pulse.
// CONFIGURATION
//   RETRIGGER_EN defined: det in RUN with tmr_co=0 -> LOAD (timer reloaded, det_count++).
//   RETRIGGER_EN undefined: det in RUN is ignored; timer runs to tmr_co.
//   tmr_co and det in the same RUN cycle: tmr_co wins in both builds.
// STRUCTURE
//   Package detect_ctrl_pkg: state encodings (IDLE..HOLD), state width 3.
//   Sub-module tick_counter (loadable down counter with zero flag), instanced for HOLD;
//   the watchdog is a separate up counter inside detect_timer_ctrl.
// TESTING
//   start=1, det at cycle 5, tmr_co 10 cycles after tmr_en -> tmr_init@6, done once, det_count=1.
//   Watchdog: start=1, no det for 64 cycles -> timeout pulse once, busy=0, det_count=0.
//   rearm=1 with HOLD_CYC=4: tmr_co -> HOLD exactly 4 cycles -> ARMED, det_arm=1.
//   stop asserted during RUN -> IDLE next cycle, tmr_en=0, done never asserted.
//   det in RUN: RETRIGGER_EN -> tmr_init re-pulses, det_count=2; else no change.
//   256+ detections with DCNT_W=8 -> det_count holds 255; rst mid-HOLD -> all outputs 0.

Source files
------------

// File: rtl/detect_ctrl_pkg.sv
// Shared state encodings and sizing helper for the detector/timer sequencer.
package detect_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/detect_timer_ctrl_if.sv
// Control/status bundle between the system control block and the detector/timer sequencer.
interface detect_timer_ctrl_if #(
    parameter int DCNT_W = 8
);
    logic              start;
    logic              stop;
    logic              rearm;
    logic              det;
    logic              tmr_co;
    logic              det_arm;
    logic              tmr_init;
    logic              tmr_en;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [DCNT_W-1:0] det_count;
    logic [2:0]        state;

    modport master (
        output start, stop, rearm, det, tmr_co,
        input  det_arm, tmr_init, tmr_en, busy, done, timeout, det_count, state
    );

    modport slave (
        input  start, stop, rearm, det, tmr_co,
        output det_arm, tmr_init, tmr_en, busy, done, timeout, det_count, state
    );
endinterface

// File: rtl/detect_timer_ctrl_tick_counter.sv
// Loadable down counter with a zero flag; it stops at zero rather than wrapping.
module tick_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/detect_timer_ctrl.sv
// Sequencer that arms the pattern detector and loads/runs the external timer per detection.
// Optional macro RETRIGGER_EN: a detection during RUN reloads the timer.
module detect_timer_ctrl
    import detect_ctrl_pkg::*;
#(
    parameter int DCNT_W   = 8,
    parameter int TIMEOUT  = 64,
    parameter int HOLD_CYC = 4
) (
    input  logic                clk,
    input  logic                rst,
    detect_timer_ctrl_if.slave  bus
);

    localparam int              WD_W      = cnt_width(TIMEOUT);
    localparam int              HC_W      = cnt_width(HOLD_CYC);
    localparam logic            WD_EN     = (TIMEOUT > 0);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYC - 1);

    state_t            state_q;
    state_t            state_d;
    logic [WD_W-1:0]   wdog_q;
    logic [DCNT_W-1:0] det_count_q;
    logic              done_q;
    logic              timeout_q;
    logic              wd_clr;
    logic              wd_inc;
    logic              hold_load;
    logic              hold_zero;
    logic              done_set;
    logic              timeout_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // stop outranks everything; tmr_co outranks det while the timer runs.
    always_comb begin
        state_d     = state_q;
        wd_clr      = 1'b0;
        wd_inc      = 1'b0;
        hold_load   = 1'b0;
        done_set    = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.stop && bus.start) begin
                    state_d = ST_ARMED;
                    wd_clr  = 1'b1;
                end
            end
            ST_ARMED: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (bus.det) begin
                    state_d = ST_LOAD;
                end else if (WD_EN && (wdog_q == WD_LAST)) begin
                    state_d     = ST_IDLE;
                    timeout_set = 1'b1;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = bus.stop ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (bus.tmr_co) begin
                    state_d   = ST_HOLD;
                    hold_load = 1'b1;
                    done_set  = 1'b1;
                end
`ifdef RETRIGGER_EN
                else if (bus.det) begin
                    state_d = ST_LOAD;
                end
`endif
            end
            ST_HOLD: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (hold_zero) begin
                    if (bus.rearm) begin
                        state_d = ST_ARMED;
                        wd_clr  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Watchdog restarts from zero on every entry to ARMED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
        end else if (wd_clr) begin
            wdog_q <= '0;
        end else if (wd_inc) begin
            wdog_q <= wdog_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det_count_q <= '0;
        end else if ((state_q == ST_LOAD) && (det_count_q != '1)) begin
            det_count_q <= det_count_q + DCNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q    <= done_set;
            timeout_q <= timeout_set;
        end
    end

    tick_counter #(
        .W (HC_W)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .load_val (HOLD_LAST),
        .dec      (state_q == ST_HOLD),
        .zero     (hold_zero)
    );

    assign bus.det_arm   = (state_q == ST_ARMED);
    assign bus.tmr_init  = (state_q == ST_LOAD);
    assign bus.tmr_en    = (state_q == ST_RUN);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.timeout   = timeout_q;
    assign bus.det_count = det_count_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_detect_timer_ctrl.sv
// Directed bench for detect_timer_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_detect_timer_ctrl;

    logic clk;
    logic rst;
    int   vecCount;
    int   missCount;

    detect_timer_ctrl_if #(.DCNT_W(8)) bus ();

    detect_timer_ctrl #(
        .DCNT_W   (8),
        .TIMEOUT  (64),
        .HOLD_CYC (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {state, det_arm, tmr_init, tmr_en, busy, done, timeout, det_count}
    logic [16:0] outs;
    assign outs = {bus.state, bus.det_arm, bus.tmr_init, bus.tmr_en, bus.busy,
                   bus.done, bus.timeout, bus.det_count};

    typedef struct {
        logic        start;
        logic        stop;
        logic        rearm;
        logic        det;
        logic        tmr_co;
        logic [16:0] expOut;
    } vec_t;

    // flags = {det_arm, tmr_init, tmr_en, busy, done, timeout}
    function automatic vec_t mk(input logic s, input logic sp, input logic ra,
                                input logic d, input logic co, input logic [2:0] st,
                                input logic [5:0] flags, input logic [7:0] cnt);
        vec_t v;
        v.start  = s;
        v.stop   = sp;
        v.rearm  = ra;
        v.det    = d;
        v.tmr_co = co;
        v.expOut = {st, flags, cnt};
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs, clock once, then settle away from the edge.
    task automatic applyStimulus(input logic s, input logic sp, input logic ra,
                                 input logic d, input logic co);
        bus.start  = s;
        bus.stop   = sp;
        bus.rearm  = ra;
        bus.det    = d;
        bus.tmr_co = co;
        @(posedge clk);
        #2;
    endtask

    task automatic doReset();
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.rearm  = 1'b0;
        bus.det    = 1'b0;
        bus.tmr_co = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset", 32'(outs), 32'h0);
        rst = 1'b0;
    endtask

    vec_t tbl[25];

    initial begin
        int initCnt, initCyc, enCnt, enFirst, doneCnt, doneCyc, toCnt, toCyc, armCnt;
        vecCount  = 0;
        missCount = 0;

        tbl[0]  = mk(1,0,0,0,0, 3'd1, 6'b100100, 8'd0);
        tbl[1]  = mk(0,0,0,0,0, 3'd1, 6'b100100, 8'd0);
        tbl[2]  = mk(0,0,0,1,0, 3'd2, 6'b010100, 8'd0);
        tbl[3]  = mk(0,0,0,0,0, 3'd3, 6'b001100, 8'd1);
        tbl[4]  = mk(0,0,0,0,0, 3'd3, 6'b001100, 8'd1);
        tbl[5]  = mk(0,0,0,0,1, 3'd4, 6'b000110, 8'd1);
        tbl[6]  = mk(0,0,0,0,0, 3'd4, 6'b000100, 8'd1);
        tbl[7]  = mk(0,0,0,0,0, 3'd4, 6'b000100, 8'd1);
        tbl[8]  = mk(0,0,0,0,0, 3'd4, 6'b000100, 8'd1);
        tbl[9]  = mk(0,0,1,0,0, 3'd1, 6'b100100, 8'd1);
        tbl[10] = mk(0,0,0,0,1, 3'd1, 6'b100100, 8'd1);
        tbl[11] = mk(0,0,0,1,0, 3'd2, 6'b010100, 8'd1);
        tbl[12] = mk(0,0,0,1,0, 3'd3, 6'b001100, 8'd2);
        tbl[13] = mk(0,0,0,1,1, 3'd4, 6'b000110, 8'd2);
        tbl[14] = mk(0,0,0,0,0, 3'd4, 6'b000100, 8'd2);
        tbl[15] = mk(0,0,0,0,0, 3'd4, 6'b000100, 8'd2);
        tbl[16] = mk(0,0,0,0,0, 3'd4, 6'b000100, 8'd2);
        tbl[17] = mk(0,0,0,0,0, 3'd0, 6'b000000, 8'd2);
        tbl[18] = mk(0,0,0,1,0, 3'd0, 6'b000000, 8'd2);
        tbl[19] = mk(1,1,0,0,0, 3'd0, 6'b000000, 8'd2);
        tbl[20] = mk(1,0,0,0,0, 3'd1, 6'b100100, 8'd2);
        tbl[21] = mk(0,0,0,1,0, 3'd2, 6'b010100, 8'd2);
        tbl[22] = mk(0,0,0,0,0, 3'd3, 6'b001100, 8'd3);
        tbl[23] = mk(0,1,0,0,0, 3'd0, 6'b000000, 8'd3);
        tbl[24] = mk(0,0,0,0,1, 3'd0, 6'b000000, 8'd3);

        doReset();
        for (int i = 0; i < 25; i++) begin
            applyStimulus(tbl[i].start, tbl[i].stop, tbl[i].rearm, tbl[i].det, tbl[i].tmr_co);
            checkOutput($sformatf("vec%0d", i), 32'(outs), 32'(tbl[i].expOut));
        end

        // Full transaction: det at cycle 5, tmr_co ten cycles into tmr_en.
        doReset();
        initCnt = 0; initCyc = -1; enCnt = 0; enFirst = -1; doneCnt = 0; doneCyc = -1;
        for (int k = 0; k < 30; k++) begin
            applyStimulus(k == 0, 1'b0, 1'b0, k == 5, k == 17);
            if (bus.tmr_init) begin initCnt++; if (initCyc < 0) initCyc = k + 1; end
            if (bus.tmr_en)   begin enCnt++;   if (enFirst < 0) enFirst = k + 1; end
            if (bus.done)     begin doneCnt++; doneCyc = k + 1; end
        end
        checkOutput("flow_init_count", 32'(initCnt), 32'd1);
        checkOutput("flow_init_cycle", 32'(initCyc), 32'd6);
        checkOutput("flow_en_first",   32'(enFirst), 32'd7);
        checkOutput("flow_en_count",   32'(enCnt),   32'd11);
        checkOutput("flow_done_count", 32'(doneCnt), 32'd1);
        checkOutput("flow_done_cycle", 32'(doneCyc), 32'd18);
        checkOutput("flow_det_count",  32'(bus.det_count), 32'd1);
        checkOutput("flow_idle",       32'(bus.busy), 32'd0);

        // Watchdog: 64 ARMED cycles with no detection, then a single timeout pulse.
        doReset();
        toCnt = 0; toCyc = -1; armCnt = 0;
        for (int k = 0; k < 72; k++) begin
            applyStimulus(k == 0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (bus.det_arm) armCnt++;
            if (bus.timeout) begin toCnt++; toCyc = k + 1; end
        end
        checkOutput("wdog_armed_cycles", 32'(armCnt), 32'd64);
        checkOutput("wdog_pulse_count",  32'(toCnt),  32'd1);
        checkOutput("wdog_pulse_cycle",  32'(toCyc),  32'd65);
        checkOutput("wdog_busy",         32'(bus.busy), 32'd0);
        checkOutput("wdog_det_count",    32'(bus.det_count), 32'd0);

        // Detection while the timer runs.
        doReset();
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
`ifdef RETRIGGER_EN
        checkOutput("retrig_init", 32'(bus.tmr_init), 32'd1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("retrig_count", 32'(bus.det_count), 32'd2);
`else
        checkOutput("retrig_init", 32'(bus.tmr_init), 32'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("retrig_count", 32'(bus.det_count), 32'd1);
`endif
        checkOutput("retrig_en", 32'(bus.tmr_en), 32'd1);

        // Saturation: 260 detections, each aborted with stop after LOAD.
        doReset();
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            applyStimulus(0, 0, 0, 1, 0);
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput($sformatf("sat%0d", i), 32'(bus.det_count),
                        (i + 1 > 255) ? 32'd255 : 32'(i + 1));
            applyStimulus(0, 1, 0, 0, 0);
        end

        // Asynchronous reset in the middle of HOLD.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("hold_reached", 32'(bus.state), 32'd4);
        #1 rst = 1'b1;
        #1 checkOutput("rst_mid_hold", 32'(outs), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
